// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller.
// Tracks the EX/MEM and MEM/WB destination registers, selects EX operand
// forwarding, and raises load-use stalls and taken-branch flushes.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       ex_rs1_i,
   input  logic [4:0]       ex_rs2_i,
   input  logic [4:0]       ex_rsd_i,
   input  logic [2:0]       ex_Op_i,
   input  logic             ex_valid_i,
   input  logic             ex_branch_i,
   output logic             stall_o,
   output logic             flush_o,
   output logic [1:0]       fwdA_o,
   output logic [1:0]       fwdB_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_memValid;
   logic [4:0]       r_memRsd;
   logic             r_memLoad;
   logic             r_wbValid;
   logic [4:0]       r_wbRsd;
   logic             w_exWrites;
   logic             w_exLoad;
   logic             w_loadUse;
   logic             w_takenBranch;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   // Classify the EX instruction and detect the raw hazard conditions.
   always_comb begin
      w_exWrites    = (ex_Op_i == 3'b000) || (ex_Op_i == 3'b001) || (ex_Op_i == 3'b010);
      w_exLoad      = (ex_Op_i == 3'b010);
      w_loadUse     = ex_valid_i && w_exLoad && (ex_rsd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rsd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rsd_i)));
      w_takenBranch = ex_valid_i && (ex_Op_i == 3'b100) && ex_branch_i;
   end

   // Destination tracker: always shifts, bubbles arrive via ex_valid_i only.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_memValid <= 1'b0;
         r_memRsd   <= 5'd0;
         r_memLoad  <= 1'b0;
         r_wbValid  <= 1'b0;
         r_wbRsd    <= 5'd0;
      end else begin
         r_memValid <= ex_valid_i && w_exWrites;
         r_memRsd   <= ex_rsd_i;
         r_memLoad  <= w_exLoad;
         r_wbValid  <= r_memValid;
         r_wbRsd    <= r_memRsd;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and stall/flush; flush wins, STALL masks a repeat stall, FLUSH masks both.
   always_comb begin
      w_nextState = r_state;
      stall_o     = 1'b0;
      flush_o     = 1'b0;
      if (rst_i) begin
         case (r_state)
            RUN: begin
               if (w_takenBranch) begin
                  flush_o     = 1'b1;
                  w_nextState = FLUSH;
               end else if (w_loadUse) begin
                  stall_o     = 1'b1;
                  w_nextState = STALL;
               end
            end
            STALL: begin
               if (w_takenBranch) begin
                  flush_o     = 1'b1;
                  w_nextState = FLUSH;
               end else begin
                  w_nextState = RUN;
               end
            end
            FLUSH: begin
               w_nextState = RUN;
            end
            default: begin
               w_nextState = RUN;
            end
         endcase
      end
   end

   // Operand forwarding: newest non-load producer first, then MEM/WB, else register file.
   always_comb begin
      fwdA_o = 2'b00;
      fwdB_o = 2'b00;
      if (rst_i && ex_valid_i) begin
         if (r_memValid && (r_memRsd != 5'd0) && (r_memRsd == ex_rs1_i) && !r_memLoad) begin
            fwdA_o = 2'b10;
         end else if (r_wbValid && (r_wbRsd != 5'd0) && (r_wbRsd == ex_rs1_i)) begin
            fwdA_o = 2'b01;
         end
         if (r_memValid && (r_memRsd != 5'd0) && (r_memRsd == ex_rs2_i) && !r_memLoad) begin
            fwdB_o = 2'b10;
         end else if (r_wbValid && (r_wbRsd != 5'd0) && (r_wbRsd == ex_rs2_i)) begin
            fwdB_o = 2'b01;
         end
      end
   end

   // Saturating event counters for stalls and flushes.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (stall_o && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (flush_o && (r_flushCnt != {CNT_W{1'b1}})) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt_o = r_stallCnt;
   assign flush_cnt_o = r_flushCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: each scenario task drives a table of
// cycles, pushes the expected outputs to a scoreboard and compares on pop.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       v;
      logic [2:0] op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rsd;
      logic       br;
      logic [4:0] irs1;
      logic [4:0] irs2;
      logic       u1;
      logic       u2;
      logic [5:0] expv;
   } step_t;

   typedef struct {
      string      name;
      logic [5:0] expv;
   } sbEntry_t;

   logic             clk;
   logic             rstN;
   logic [4:0]       idRs1;
   logic [4:0]       idRs2;
   logic             idUse1;
   logic             idUse2;
   logic [4:0]       exRs1;
   logic [4:0]       exRs2;
   logic [4:0]       exRsd;
   logic [2:0]       exOp;
   logic             exValid;
   logic             exBranch;
   logic             stall;
   logic             flush;
   logic [1:0]       fwdA;
   logic [1:0]       fwdB;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   int               total = 0;
   int               bad = 0;
   logic [CNT_W-1:0] expStallCnt = '0;
   logic [CNT_W-1:0] expFlushCnt = '0;
   sbEntry_t         sb[$];

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rstN),
      .id_rs1_i     (idRs1),
      .id_rs2_i     (idRs2),
      .id_use_rs1_i (idUse1),
      .id_use_rs2_i (idUse2),
      .ex_rs1_i     (exRs1),
      .ex_rs2_i     (exRs2),
      .ex_rsd_i     (exRsd),
      .ex_Op_i      (exOp),
      .ex_valid_i   (exValid),
      .ex_branch_i  (exBranch),
      .stall_o      (stall),
      .flush_o      (flush),
      .fwdA_o       (fwdA),
      .fwdB_o       (fwdB),
      .stall_cnt_o  (stallCnt),
      .flush_cnt_o  (flushCnt)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got=running want=finished");
      $fatal(1, "[TB] time limit reached");
   end

   // Build one cycle of stimulus with its expected {stall,flush,fwdA,fwdB}.
   function automatic step_t mk(input int v, input int op, input int rs1, input int rs2,
                                input int rsd, input int br, input int irs1, input int irs2,
                                input int u1, input int u2, input int expv);
      step_t r;
      r.v    = 1'(v);
      r.op   = 3'(op);
      r.rs1  = 5'(rs1);
      r.rs2  = 5'(rs2);
      r.rsd  = 5'(rsd);
      r.br   = 1'(br);
      r.irs1 = 5'(irs1);
      r.irs2 = 5'(irs2);
      r.u1   = 1'(u1);
      r.u2   = 1'(u2);
      r.expv = 6'(expv);
      return r;
   endfunction

   // Drive one cycle's inputs and record the expected outputs.
   task automatic applyStimulus(input step_t s, input string nm);
      exValid  = s.v;
      exOp     = s.op;
      exRs1    = s.rs1;
      exRs2    = s.rs2;
      exRsd    = s.rsd;
      exBranch = s.br;
      idRs1    = s.irs1;
      idRs2    = s.irs2;
      idUse1   = s.u1;
      idUse2   = s.u2;
      sb.push_back('{nm, s.expv});
   endtask

   // Let the posedge consume the cycle and advance the counter model.
   task automatic tick(input logic eStall, input logic eFlush);
      @(posedge clk);
      if (rstN) begin
         if (eStall && (expStallCnt != {CNT_W{1'b1}})) expStallCnt = expStallCnt + 1'b1;
         if (eFlush && (expFlushCnt != {CNT_W{1'b1}})) expFlushCnt = expFlushCnt + 1'b1;
      end
      @(negedge clk);
   endtask

   // Reset holds every output low even with a load-use pattern on the inputs.
   task automatic test_reset();
      sbEntry_t e;
      rstN = 1'b0;
      applyStimulus(mk(1, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 0), "reset");
      for (int i = 0; i < 2; i++) begin
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         total++;
         if ({stallCnt, flushCnt} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_cnt[%0d]: got=%h want=00", i, {stallCnt, flushCnt});
         end
         if (i == 0) sb.push_back('{"reset", 6'b0});
         @(posedge clk);
         @(negedge clk);
      end
      rstN = 1'b1;
   endtask

   // ALU producer forwarded from EX/MEM, then MEM/WB; no stall.
   task automatic test_back_to_back();
      step_t    s[$];
      sbEntry_t e;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b000, 1, 2, 5, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b000, 5, 3, 6, 0, 5, 0, 1, 0, 'b00_10_00));
      s.push_back(mk(1, 'b000, 5, 5, 8, 0, 0, 0, 0, 0, 'b00_01_01));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      foreach (s[i]) begin
         applyStimulus(s[i], "back_to_back");
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         tick(e.expv[5], e.expv[4]);
      end
      total++;
      if (stallCnt !== expStallCnt) begin
         bad++;
         $display("[TB] FAIL b2b_stall_cnt: got=%0d want=%0d", stallCnt, expStallCnt);
      end
   endtask

   // Store and no-op do not write; I-type does; untaken branch does not flush.
   task automatic test_nonwriting();
      step_t    s[$];
      sbEntry_t e;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b011, 1, 2, 5, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b101, 5, 5, 6, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b001, 5, 6, 9, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b100, 9, 9, 10, 0, 0, 0, 0, 0, 'b00_10_10));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      foreach (s[i]) begin
         applyStimulus(s[i], "nonwriting");
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         tick(e.expv[5], e.expv[4]);
      end
   endtask

   // Load-use stall on rs2, bubble, consumer forwards from MEM/WB; load in MEM is not forwarded.
   task automatic test_load_use();
      step_t    s[$];
      sbEntry_t e;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b10_00_00));
      s.push_back(mk(0, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b00_00_00));
      s.push_back(mk(1, 'b000, 4, 7, 9, 0, 0, 0, 0, 0, 'b00_00_01));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 2, 0, 7, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b000, 7, 7, 9, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      foreach (s[i]) begin
         applyStimulus(s[i], "load_use");
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         tick(e.expv[5], e.expv[4]);
      end
      total++;
      if (stallCnt !== expStallCnt) begin
         bad++;
         $display("[TB] FAIL load_use_stall_cnt: got=%0d want=%0d", stallCnt, expStallCnt);
      end
   endtask

   // A stale load-use view right after a stall is ignored for exactly one cycle.
   task automatic test_stall_once();
      step_t    s[$];
      sbEntry_t e;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 3, 0, 8, 0, 8, 0, 1, 0, 'b10_00_00));
      s.push_back(mk(1, 'b010, 3, 0, 8, 0, 8, 0, 1, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 3, 0, 8, 0, 8, 0, 1, 0, 'b10_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 3, 0, 8, 0, 8, 8, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      foreach (s[i]) begin
         applyStimulus(s[i], "stall_once");
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         tick(e.expv[5], e.expv[4]);
      end
      total++;
      if (stallCnt !== expStallCnt) begin
         bad++;
         $display("[TB] FAIL stall_once_cnt: got=%0d want=%0d", stallCnt, expStallCnt);
      end
   endtask

   // Taken branch flushes, FLUSH masks the stale view, and a branch during STALL still flushes.
   task automatic test_branch_flush();
      step_t    s[$];
      sbEntry_t e;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b100, 3, 4, 7, 1, 7, 7, 1, 1, 'b01_00_00));
      s.push_back(mk(1, 'b100, 3, 4, 7, 1, 7, 7, 1, 1, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b10_00_00));
      s.push_back(mk(1, 'b100, 7, 0, 0, 1, 0, 7, 0, 1, 'b01_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b100, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      foreach (s[i]) begin
         applyStimulus(s[i], "branch_flush");
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         tick(e.expv[5], e.expv[4]);
      end
      total++;
      if (flushCnt !== expFlushCnt) begin
         bad++;
         $display("[TB] FAIL flush_cnt: got=%0d want=%0d", flushCnt, expFlushCnt);
      end
   endtask

   // Writes to x0 never stall and are never forwarded.
   task automatic test_x0();
      step_t    s[$];
      sbEntry_t e;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b010, 0, 0, 0, 0, 0, 0, 1, 1, 'b00_00_00));
      s.push_back(mk(1, 'b000, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(1, 'b000, 0, 0, 1, 0, 0, 0, 0, 0, 'b00_00_00));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00_00_00));
      foreach (s[i]) begin
         applyStimulus(s[i], "x0");
         #2;
         e = sb.pop_front();
         total++;
         if ({stall, flush, fwdA, fwdB} !== e.expv) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got=%b want=%b", e.name, i, {stall, flush, fwdA, fwdB}, e.expv);
         end
         tick(e.expv[5], e.expv[4]);
      end
   endtask

   // Twenty load-use events drive the 4-bit stall counter into saturation.
   task automatic test_saturation();
      sbEntry_t e;
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (k == 0) applyStimulus(mk(1, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b10_00_00), "saturation");
            else        applyStimulus(mk(0, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b00_00_00), "saturation");
            #2;
            e = sb.pop_front();
            total++;
            if ({stall, flush, fwdA, fwdB} !== e.expv) begin
               bad++;
               $display("[TB] FAIL %s[%0d.%0d]: got=%b want=%b", e.name, n, k, {stall, flush, fwdA, fwdB}, e.expv);
            end
            tick(e.expv[5], e.expv[4]);
         end
         total++;
         if (stallCnt !== expStallCnt) begin
            bad++;
            $display("[TB] FAIL sat_cnt[%0d]: got=%0d want=%0d", n, stallCnt, expStallCnt);
         end
      end
      total++;
      if (stallCnt !== 4'd15) begin
         bad++;
         $display("[TB] FAIL sat_final: got=%0d want=15", stallCnt);
      end
   endtask

   // Reset asserted between edges during a stall clears everything immediately.
   task automatic test_async_reset();
      sbEntry_t e;
      applyStimulus(mk(1, 'b000, 1, 2, 5, 0, 0, 0, 0, 0, 'b00_00_00), "async_pre");
      #2;
      e = sb.pop_front();
      total++;
      if ({stall, flush, fwdA, fwdB} !== e.expv) begin
         bad++;
         $display("[TB] FAIL %s: got=%b want=%b", e.name, {stall, flush, fwdA, fwdB}, e.expv);
      end
      tick(e.expv[5], e.expv[4]);
      applyStimulus(mk(1, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b10_00_00), "async_stall");
      #2;
      e = sb.pop_front();
      total++;
      if ({stall, flush, fwdA, fwdB} !== e.expv) begin
         bad++;
         $display("[TB] FAIL %s: got=%b want=%b", e.name, {stall, flush, fwdA, fwdB}, e.expv);
      end
      #1;
      rstN = 1'b0;
      sb.push_back('{"async_mid", 6'b00_00_00});
      expStallCnt = '0;
      expFlushCnt = '0;
      #1;
      e = sb.pop_front();
      total++;
      if ({stall, flush, fwdA, fwdB} !== e.expv) begin
         bad++;
         $display("[TB] FAIL %s: got=%b want=%b", e.name, {stall, flush, fwdA, fwdB}, e.expv);
      end
      total++;
      if ({stallCnt, flushCnt} !== {expStallCnt, expFlushCnt}) begin
         bad++;
         $display("[TB] FAIL async_cnt: got=%h want=%h", {stallCnt, flushCnt}, {expStallCnt, expFlushCnt});
      end
      @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(mk(1, 'b000, 5, 7, 9, 0, 0, 0, 0, 0, 'b00_00_00), "async_reader");
      #2;
      e = sb.pop_front();
      total++;
      if ({stall, flush, fwdA, fwdB} !== e.expv) begin
         bad++;
         $display("[TB] FAIL %s: got=%b want=%b", e.name, {stall, flush, fwdA, fwdB}, e.expv);
      end
      tick(e.expv[5], e.expv[4]);
      applyStimulus(mk(1, 'b010, 2, 0, 7, 0, 0, 7, 0, 1, 'b10_00_00), "async_post");
      #2;
      e = sb.pop_front();
      total++;
      if ({stall, flush, fwdA, fwdB} !== e.expv) begin
         bad++;
         $display("[TB] FAIL %s: got=%b want=%b", e.name, {stall, flush, fwdA, fwdB}, e.expv);
      end
      tick(e.expv[5], e.expv[4]);
      total++;
      if (stallCnt !== expStallCnt) begin
         bad++;
         $display("[TB] FAIL async_post_cnt: got=%0d want=%0d", stallCnt, expStallCnt);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_back_to_back();
      test_nonwriting();
      test_load_use();
      test_stall_once();
      test_branch_flush();
      test_x0();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
